// File: rtl/cfu_mac_seq.sv
// cfu_mac_seq: buffered 4-lane int8 dot-product sequencer on the CFU command port.
// Optional build macro CFU_MAC_SAT_EN: accumulator saturates to int32 instead of wrapping.
module cfu_mac_seq #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] F_SET_IN  = 7'd1;
    localparam logic [6:0] F_SET_FLT = 7'd2;
    localparam logic [6:0] F_WRITE   = 7'd3;
    localparam logic [6:0] F_RUN     = 7'd4;
    localparam logic [6:0] F_CLEAR   = 7'd5;
    localparam logic [6:0] F_STATUS  = 7'd6;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Handshakes: cmd and rsp are valid/ready channels; a transfer occurs on a
    // posedge where valid && ready, and a producer holds its payload stable
    // while valid is high and the transfer has not yet happened.

    state_t        state_q, state_d;
    logic [15:0]   in_off_q, flt_off_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] rd_ptr_q, last_q;
    logic [31:0]   psum_q, acc_q, rsp_data_q;
    logic [31:0]   buf_in_mem  [DEPTH];
    logic [31:0]   buf_flt_mem [DEPTH];

    logic          cmd_fire;
    logic [6:0]    funct7;
    logic [AW:0]   run_n, n_eff;
    logic          full;
    logic          wr_en;
    logic [31:0]   lane_sum;
    logic [31:0]   acc_fold;
    logic [2:0]    unused_funct_low;

    // 16-bit offset-adjusted lanes, 32-bit wrapping sum of the four products.
    function automatic logic [31:0] lane_dot(input logic [31:0] a, input logic [31:0] b,
                                             input logic [15:0] a_off, input logic [15:0] b_off);
        logic signed [15:0] x, y;
        logic signed [31:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            x   = {{8{a[8*i+7]}}, a[8*i +: 8]} + a_off;
            y   = {{8{b[8*i+7]}}, b[8*i +: 8]} + b_off;
            sum = sum + 32'(x) * 32'(y);
        end
        return sum;
    endfunction

    function automatic logic [31:0] acc_add(input logic [31:0] acc, input logic [31:0] p);
`ifdef CFU_MAC_SAT_EN
        logic [32:0] s;
        s = {acc[31], acc} + {p[31], p};
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return s[31:0];
`else
        return acc + p;
`endif
    endfunction

    assign funct7           = cmd_payload_function_id[9:3];
    assign unused_funct_low = cmd_payload_function_id[2:0];
    assign cmd_ready        = (state_q == S_IDLE) && !rsp_valid;
    assign cmd_fire         = cmd_valid && cmd_ready;
    assign run_n            = cmd_payload_inputs_0[AW:0];
    assign n_eff            = (run_n < count_q) ? run_n : count_q;
    assign full             = (count_q == FULL_COUNT);
    assign wr_en            = cmd_fire && (funct7 == F_WRITE) && !full;
    assign lane_sum         = lane_dot(buf_in_mem[rd_ptr_q], buf_flt_mem[rd_ptr_q],
                                       in_off_q, flt_off_q);
    assign acc_fold         = acc_add(acc_q, psum_q);

    assign rsp_valid             = (state_q == S_RESP);
    assign rsp_payload_outputs_0 = rsp_data_q;
    assign dbg_state             = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if ((funct7 == F_RUN) && (n_eff != '0)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RUN: begin
                if (rd_ptr_q == last_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_in_mem[count_q[AW-1:0]]  <= cmd_payload_inputs_0;
            buf_flt_mem[count_q[AW-1:0]] <= cmd_payload_inputs_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_off_q   <= '0;
            flt_off_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            psum_q     <= '0;
            acc_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (funct7)
                            F_SET_IN: begin
                                in_off_q   <= cmd_payload_inputs_0[15:0];
                                rsp_data_q <= '0;
                            end
                            F_SET_FLT: begin
                                flt_off_q  <= cmd_payload_inputs_0[15:0];
                                rsp_data_q <= '0;
                            end
                            F_WRITE: begin
                                if (full) begin
                                    rsp_data_q <= 32'hFFFF_FFFF;
                                end else begin
                                    count_q    <= count_q + 1'b1;
                                    rsp_data_q <= 32'(count_q) + 32'd1;
                                end
                            end
                            F_RUN: begin
                                acc_q      <= cmd_payload_inputs_1;
                                rsp_data_q <= cmd_payload_inputs_1;
                                rd_ptr_q   <= '0;
                                last_q     <= AW'(n_eff - 1'b1);
                            end
                            F_CLEAR: begin
                                count_q    <= '0;
                                rsp_data_q <= '0;
                            end
                            F_STATUS: rsp_data_q <= 32'(count_q);
                            default:  rsp_data_q <= '0;
                        endcase
                    end
                end
                S_RUN: begin
                    psum_q   <= lane_sum;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    // psum_q only holds a real partial sum after the first read.
                    if (rd_ptr_q != '0) begin
                        acc_q <= acc_fold;
                    end
                end
                S_DRAIN: begin
                    acc_q      <= acc_fold;
                    rsp_data_q <= acc_fold;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_mac_seq.sv
// Bench for cfu_mac_seq: directed and random commands against a queue-based model
// with a single per-cycle response checker.
module tb_cfu_mac_seq;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [6:0] F_SET_IN  = 7'd1;
    localparam logic [6:0] F_SET_FLT = 7'd2;
    localparam logic [6:0] F_WRITE   = 7'd3;
    localparam logic [6:0] F_RUN     = 7'd4;
    localparam logic [6:0] F_CLEAR   = 7'd5;
    localparam logic [6:0] F_STATUS  = 7'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_payload_outputs_0;
    logic [1:0]  dbg_state;

    cfu_mac_seq #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .dbg_state               (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          exp_at_q[$];
    int          hold_n = 0;
    bit          in_rsp = 1'b0;
    logic [31:0] cur_rsp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_in[$];
    logic [31:0] m_flt[$];
    logic [15:0] m_in_off  = '0;
    logic [15:0] m_flt_off = '0;

    function automatic int lane_val(input logic [7:0] b, input logic [15:0] off);
        int v;
        v = int'($signed(b)) + int'($signed(off));
        return int'(shortint'(v));
    endfunction

    function automatic logic [31:0] mdl_run(input int ne, input logic [31:0] bias);
        int acc;
        int ps;
        longint t;
        acc = int'(bias);
        for (int e = 0; e < ne; e++) begin
            ps = 0;
            for (int l = 0; l < 4; l++) begin
                ps += lane_val(m_in[e][8*l +: 8], m_in_off) * lane_val(m_flt[e][8*l +: 8], m_flt_off);
            end
`ifdef CFU_MAC_SAT_EN
            t = longint'(acc) + longint'(ps);
            if (t > 64'sd2147483647) t = 64'sd2147483647;
            if (t < -64'sd2147483648) t = -64'sd2147483648;
            acc = int'(t);
`else
            t = 0;
            acc = acc + ps;
`endif
        end
        return acc;
    endfunction

    task automatic model_apply(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rsp, output int lat);
        int n, ne;
        rsp = '0;
        lat = 1;
        case (f7)
            F_SET_IN:  m_in_off  = a[15:0];
            F_SET_FLT: m_flt_off = a[15:0];
            F_WRITE: begin
                if (m_in.size() < DEPTH) begin
                    m_in.push_back(a);
                    m_flt.push_back(b);
                    rsp = m_in.size();
                end else begin
                    rsp = 32'hFFFF_FFFF;
                end
            end
            F_RUN: begin
                n   = int'(a) & (2 * DEPTH - 1);
                ne  = (n < m_in.size()) ? n : m_in.size();
                rsp = mdl_run(ne, b);
                lat = (ne == 0) ? 1 : ne + 2;
            end
            F_CLEAR: begin
                m_in.delete();
                m_flt.delete();
            end
            F_STATUS: rsp = m_in.size();
            default: rsp = '0;
        endcase
    endtask

    // ---------------- per-cycle response checker ----------------
    always @(negedge clk) begin
        if (reset) begin
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
        end else begin
            if (rsp_valid) begin
                check("cmd_ready_low_while_rsp", {31'd0, cmd_ready}, 32'd0);
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got data %h, expected no response (cycle %0d)",
                                 rsp_payload_outputs_0, cyc);
                        cur_rsp = rsp_payload_outputs_0;
                    end else begin
                        cur_rsp = exp_q.pop_front();
                        check("rsp_data", rsp_payload_outputs_0, cur_rsp);
                        check("rsp_cycle", 32'(cyc), 32'(exp_at_q.pop_front()));
                    end
                    in_rsp = 1'b1;
                end else begin
                    check("rsp_stable", rsp_payload_outputs_0, cur_rsp);
                end
                if (hold_n > 0) begin
                    rsp_ready = 1'b0;
                    hold_n--;
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                if (rsp_ready) in_rsp = 1'b0;
            end else begin
                if (exp_at_q.size() > 0 && cyc > exp_at_q[0]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_late: got no rsp_valid, expected %h by cycle %0d",
                             exp_q[0], exp_at_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_at_q.pop_front());
                end
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_cmd(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_rsp, output logic [31:0] m_rsp, output int m_lat);
        int waited;
        waited = 0;
        m_rsp  = '0;
        m_lat  = 0;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got cmd_ready=0, expected 1 within 300 cycles");
            return;
        end
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {f7, 3'($urandom_range(0, 7))};
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        model_apply(f7, a, b, m_rsp, m_lat);
        if (expect_rsp) begin
            exp_q.push_back(m_rsp);
            exp_at_q.push_back(cyc + m_lat);
        end
        @(negedge clk);
        cmd_valid            = 1'b0;
        cmd_payload_inputs_0 = $urandom;
        cmd_payload_inputs_1 = $urandom;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || rsp_valid || !cmd_ready) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        int          lat;
        int          sel;
        int          waited;
        logic [6:0]  f7;
        logic [31:0] a;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_rsp_data", rsp_payload_outputs_0, 32'd0);

        do_cmd(F_STATUS, 32'd0, 32'd0, 1, r, lat);
        check("model_status_reset", r, 32'd0);

        // single-entry dot product with an input offset
        do_cmd(F_SET_IN, 32'd128, 32'd0, 1, r, lat);
        do_cmd(F_SET_FLT, 32'd0, 32'd0, 1, r, lat);
        do_cmd(F_WRITE, 32'h0101_0101, 32'h0202_0202, 1, r, lat);
        check("model_write_first", r, 32'd1);
        do_cmd(F_RUN, 32'd1, 32'd10, 1, r, lat);
        check("model_run_1042", r, 32'd1042);
        check("model_run_latency_1", 32'(lat), 32'd3);

        // fill past capacity
        do_cmd(F_CLEAR, 32'd0, 32'd0, 1, r, lat);
        for (int i = 0; i <= DEPTH; i++) begin
            do_cmd(F_WRITE, $urandom, $urandom, 1, r, lat);
        end
        check("model_write_full", r, 32'hFFFF_FFFF);
        do_cmd(F_STATUS, 32'd0, 32'd0, 1, r, lat);
        check("model_status_full", r, 32'(DEPTH));
        do_cmd(F_CLEAR, 32'd0, 32'd0, 1, r, lat);
        do_cmd(F_STATUS, 32'd0, 32'd0, 1, r, lat);

        // empty run returns bias; clamped N
        do_cmd(F_RUN, 32'd0, 32'd7, 1, r, lat);
        check("model_empty_run", r, 32'd7);
        check("model_empty_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) do_cmd(F_WRITE, $urandom, $urandom, 1, r, lat);
        do_cmd(F_RUN, 32'd5, $urandom, 1, r, lat);
        check("model_clamp_latency", 32'(lat), 32'd5);

        // long response hold with a blocked command
        wait_idle();
        hold_n = 5;
        do_cmd(F_RUN, 32'd3, 32'd100, 1, r, lat);
        waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {F_WRITE, 3'd0};
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        do_cmd(F_STATUS, 32'd0, 32'd0, 1, r, lat);
        check("model_status_after_block", r, 32'd3);

        // reset in the middle of a run
        wait_idle();
        for (int i = 0; i < 8; i++) do_cmd(F_WRITE, $urandom, $urandom, 1, r, lat);
        wait_idle();
        do_cmd(F_RUN, 32'd10, 32'd1, 0, r, lat);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_at_q.delete();
        m_in.delete();
        m_flt.delete();
        m_in_off  = '0;
        m_flt_off = '0;
        repeat (3) @(negedge clk);
        do_cmd(F_STATUS, 32'd0, 32'd0, 1, r, lat);
        check("model_status_after_reset", r, 32'd0);

        // accumulator overflow
        do_cmd(F_SET_IN, 32'd0, 32'd0, 1, r, lat);
        do_cmd(F_SET_FLT, 32'd0, 32'd0, 1, r, lat);
        for (int i = 0; i < DEPTH; i++) do_cmd(F_WRITE, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1, r, lat);
        do_cmd(F_RUN, 32'(DEPTH), 32'h7FFF_0000, 1, r, lat);
`ifdef CFU_MAC_SAT_EN
        check("model_overflow", r, 32'h7FFF_FFFF);
`else
        check("model_overflow", r, 32'h800E_C040);
`endif

        // random traffic
        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 99);
            a   = $urandom;
            if (sel < 40)      f7 = F_WRITE;
            else if (sel < 55) f7 = F_RUN;
            else if (sel < 62) f7 = F_SET_IN;
            else if (sel < 69) f7 = F_SET_FLT;
            else if (sel < 73) f7 = F_CLEAR;
            else if (sel < 85) f7 = F_STATUS;
            else if (sel < 88) f7 = 7'd0;
            else               f7 = 7'($urandom_range(7, 127));
            do_cmd(f7, a, $urandom, 1, r, lat);
        end

        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_mac_seq.md
# cfu_mac_seq

- CFU-side sequencer that turns the 4-lane SIMD int8 MAC into a multi-cycle dot-product engine.
- Software streams packed input/filter word pairs into a local buffer, then issues one RUN command.
- An FSM walks the buffer one word per cycle through a registered 4-lane MAC stage, accumulates onto a software-supplied bias and returns a single result.
- Sits directly on the CPU custom-instruction port, replacing per-word MAC instructions in conv inner loops.

## Interface
- DEPTH, 16: buffer entries (word pairs); power of two, 2..256; AW = $clog2(DEPTH).
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE with no response pending.
- cmd_payload_function_id  in  10  funct7 = bits [9:3]; bits [2:0] ignored.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- rsp_valid  out  1  response present; reset 0.
- rsp_ready  in  1  host accepts response.
- rsp_payload_outputs_0  out  32  result; reset 0; stable while rsp_valid.

## Operation
- Commands by funct7:
  - 1 SET_IN_OFF: InputOffset <= in0[15:0]; returns 0.
  - 2 SET_FLT_OFF: FilterOffset <= in0[15:0]; returns 0.
  - 3 WRITE: if count<DEPTH, buf[count] <= {in0,in1}, count++, returns new count; if full, no write, returns 32'hFFFF_FFFF.
  - 4 RUN: N = in0[AW:0]; N_eff = min(N, count); acc <= in1 (bias); processes entries 0..N_eff-1; returns final acc.
  - 5 CLEAR: count <= 0; returns 0.
  - 6 STATUS: returns count zero-extended.
  - Other funct7: returns 0.
- Buffer contents persist across RUNs. Only CLEAR or reset empties it.
- Reset values: offsets 0, count 0, acc 0, state IDLE.
- FSM:
  - IDLE: accepts a command. RUN with N_eff>0 goes to RUN. All other commands go to RESP.
  - RUN: rd_ptr increments from 0. After reading entry N_eff-1, goes to DRAIN.
  - DRAIN: folds the last registered partial sum into acc, then goes to RESP.
  - RESP: rsp_valid high. Leaves for IDLE on the cycle rsp_valid && rsp_ready.
- Lane arithmetic:
  - Each byte is sign-extended to 16 bits, then the matching offset is added with a 16-bit wrapping add.
  - Lane product is 16x16 signed, 32-bit.
  - The four products are summed with 32-bit wrap into a registered partial sum (psum).
  - acc <= acc + psum, one psum per cycle after the first RUN cycle.
- Boundary conditions:
  - N_eff=0: acc unchanged (equals bias); response is the bias.
  - N > count: clamped to count, no error indication.
  - Reset mid-RUN: aborts immediately, no response, buffer emptied.
  - Offset writes cannot land mid-RUN, because cmd_ready is low.

## Timing
- Command accepted in cycle C.
- Config/WRITE/CLEAR/STATUS/unknown, and RUN with N_eff=0: rsp_valid in cycle C+1.
- RUN with N_eff>0:
  - RUN occupies C+1..C+N_eff.
  - DRAIN in C+N_eff+1.
  - rsp_valid in C+N_eff+2.
- rsp_valid stays high with payload frozen until rsp_ready. It falls on the cycle after the handshake, so the next command is accepted no earlier than that cycle.
- cmd_ready is combinational: (state==IDLE) && !rsp_valid.
- Simultaneous rsp handshake and new cmd_valid in the same cycle: the command is not accepted (cmd_ready low).

## Configuration
- CFU_MAC_SAT_EN defined:
  - Every acc update is computed at 33 bits.
  - The result is clamped to [-2^31, 2^31-1] before writeback; clamping applies per step.
  - psum itself still wraps.
- Undefined: acc update is 32-bit two's-complement wrap.

## Test plan
- Reset, then STATUS -> rsp_valid=0 and cmd_ready=1 after reset; STATUS returns 0 at C+1.
- SET_IN_OFF 128, SET_FLT_OFF 0, WRITE in0=0x01010101 in1=0x02020202 (returns 1), RUN N=1 bias=10 -> 4*129*2+10 = 1042, rsp_valid at C+3.
- WRITE DEPTH+1 pairs -> responses 1..DEPTH, then 0xFFFFFFFF; STATUS returns DEPTH; CLEAR then STATUS returns 0.
- RUN on empty buffer, N=0, bias=7 -> 7 at C+1. Three entries, RUN N=5 -> processes 3, rsp_valid at C+5.
- Hold rsp_ready low 5 cycles after a RUN response -> rsp_valid and payload stable, cmd_ready=0, a pending cmd_valid is not accepted. Assert reset during a RUN -> no response, STATUS afterwards returns 0.
- Offsets 0, 16 entries of 0x7F7F7F7F x 0x7F7F7F7F, RUN N=16 bias=0x7FFF0000 -> 0x7FFFFFFF with CFU_MAC_SAT_EN, 0x800EC040 without.
